// File: rtl/num_print_pkg.sv
// Shared definitions for the decimal print sequencer.
//   state_t  : sequencer states. SEND_CR / SEND_LF exist only when the
//              NUM_PRINT_CRLF_EN macro is defined.
//   CH_*     : ASCII byte constants used on the byte stream.
package num_print_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONV      = 3'd1,
        SEND_SIGN = 3'd2,
        SEND_DIG  = 3'd3
`ifdef NUM_PRINT_CRLF_EN
        ,
        SEND_CR   = 3'd4,
        SEND_LF   = 3'd5
`endif
    } state_t;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_OVF   = 8'h23;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/num_print_sequencer_div10.sv
// One divide-by-ten step on a 33-bit unsigned magnitude.
//   mag_in : magnitude to divide
//   quo    : mag_in / 10
//   rem    : mag_in % 10 (always 0..9, so 4 bits suffice)
// Division by a constant lets synthesis build a multiply/shift network
// rather than a general divider.
module div10_step (
    input  logic [32:0] mag_in,
    output logic [32:0] quo,
    output logic [3:0]  rem
);

    assign quo = mag_in / 33'd10;
    assign rem = 4'(mag_in % 33'd10);

endmodule

// File: rtl/num_print_sequencer.sv
// Converts a signed 32-bit value into a fixed-width ASCII decimal string
// (sign character plus DIGITS digits, leading zeros kept) and streams it
// byte by byte to a UART transmitter.
//
// Optional feature: define NUM_PRINT_CRLF_EN to append CR LF after the
// last digit.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : value handshake; in_ready high only in IDLE
//   in_value            : signed two's-complement value
//   tx_valid / tx_ready : byte handshake towards the UART
//   tx_data             : ASCII byte (holds last value while tx_valid=0)
//   busy                : high whenever not IDLE
//   overflow            : pulse on the acceptance cycle of an out-of-range value
module num_print_sequencer
    import num_print_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned LIMIT   = 10 ** DIGITS;
    localparam logic [32:0] LIMIT33 = 33'(LIMIT);
    localparam int          CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_t             state_reg, state_next;
    logic [32:0]        mag_reg, mag_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               neg_reg, neg_next;
    logic               ovf_reg, ovf_next;
    logic               tx_valid_reg, tx_valid_next;
    logic [7:0]         tx_data_reg, tx_data_next;
    logic [3:0]         digit_reg [DIGITS];

    logic [32:0]        in_ext;
    logic [32:0]        in_mag;
    logic               in_oor;
    logic               accept;
    logic [32:0]        div_quo;
    logic [3:0]         div_rem;
    logic [CNT_W-1:0]   cnt_dec;

    // Sign-extend before negating so -2^31 maps to +2^31 without wrapping.
    assign in_ext = {in_value[31], in_value};
    assign in_mag = in_value[31] ? (33'd0 - in_ext) : in_ext;
    // |value| >= LIMIT covers both value >= LIMIT and value <= -LIMIT.
    assign in_oor = (in_mag >= LIMIT33);
    assign accept = (state_reg == IDLE) && in_valid;

    assign in_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign overflow = accept && in_oor;
    assign tx_valid = tx_valid_reg;
    assign tx_data  = tx_data_reg;
    assign cnt_dec  = cnt_reg - CNT_W'(1);

    div10_step u_div10 (
        .mag_in (mag_reg),
        .quo    (div_quo),
        .rem    (div_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mag_reg      <= '0;
            cnt_reg      <= '0;
            neg_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            mag_reg      <= mag_next;
            cnt_reg      <= cnt_next;
            neg_reg      <= neg_next;
            ovf_reg      <= ovf_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    // Digit buffer, LSD at index 0; slot gi is written on CONV step gi.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    digit_reg[gi] <= 4'd0;
                end else if (state_reg == CONV && cnt_reg == CNT_W'(gi)) begin
                    digit_reg[gi] <= div_rem;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        mag_next      = mag_reg;
        cnt_next      = cnt_reg;
        neg_next      = neg_reg;
        ovf_next      = ovf_reg;
        tx_valid_next = tx_valid_reg;
        tx_data_next  = tx_data_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    neg_next   = in_value[31];
                    mag_next   = in_mag;
                    ovf_next   = in_oor;
                    cnt_next   = '0;
                    state_next = CONV;
                end
            end
            CONV: begin
                mag_next = div_quo;
                if (cnt_reg == CNT_LAST) begin
                    // Counter is reused as the read index, MSD first.
                    cnt_next      = CNT_LAST;
                    state_next    = SEND_SIGN;
                    tx_valid_next = 1'b1;
                    tx_data_next  = neg_reg ? CH_MINUS : CH_PLUS;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            SEND_SIGN: begin
                if (tx_ready) begin
                    state_next   = SEND_DIG;
                    tx_data_next = ovf_reg ? CH_OVF : (CH_ZERO + {4'd0, digit_reg[cnt_reg]});
                end
            end
            SEND_DIG: begin
                if (tx_ready) begin
                    if (cnt_reg == '0) begin
`ifdef NUM_PRINT_CRLF_EN
                        state_next   = SEND_CR;
                        tx_data_next = CH_CR;
`else
                        state_next    = IDLE;
                        tx_valid_next = 1'b0;
`endif
                    end else begin
                        cnt_next     = cnt_dec;
                        tx_data_next = ovf_reg ? CH_OVF : (CH_ZERO + {4'd0, digit_reg[cnt_dec]});
                    end
                end
            end
`ifdef NUM_PRINT_CRLF_EN
            SEND_CR: begin
                if (tx_ready) begin
                    state_next   = SEND_LF;
                    tx_data_next = CH_LF;
                end
            end
            SEND_LF: begin
                if (tx_ready) begin
                    state_next    = IDLE;
                    tx_valid_next = 1'b0;
                end
            end
`endif
            default: begin
                state_next    = IDLE;
                tx_valid_next = 1'b0;
            end
        endcase
    end

endmodule
